// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master controller slice.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // Upper half-word of the peripheral window; each slave owns a 4 KB page below it.
  localparam logic [15:0] PERIPH_BASE = 16'h1000;

  // Width of the slave index field taken from busAddr[15:12].
  localparam int SLV_IDX_W = 4;

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational peripheral-window decoder: flags a hit and produces the one-hot slave select.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int NUM_SLV = 4
) (
  input  logic [31:12]        busAddr,
  output logic                hit,
  output logic [NUM_SLV-1:0]  sel
);

  logic [SLV_IDX_W-1:0] idx;

  assign idx = busAddr[15:12];

  // A hit needs the peripheral base and a page index that maps onto a fitted slave.
  always_comb begin
    hit = (busAddr[31:16] == PERIPH_BASE) &&
          ({1'b0, idx} < (SLV_IDX_W + 1)'(NUM_SLV));
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (hit && (idx == SLV_IDX_W'(i))) begin
        sel[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// Bridges the CPU single-cycle data bus onto APB3 (IDLE/SETUP/ACCESS), returning read
// data with a one-cycle ready/err completion pulse.
// Optional build macro APB_TIMEOUT_EN adds an ACCESS-phase wait limit of TIMEOUT_CYC cycles.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int NUM_SLV     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    transfer,
  input  logic                    busWe,
  input  logic [31:0]             busAddr,
  input  logic [31:0]             busWData,
  output logic [31:0]             busRData,
  output logic                    ready,
  output logic                    err,
  output logic [31:0]             PADDR,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic [NUM_SLV-1:0]      PSEL,
  output logic                    PENABLE,
  input  logic [NUM_SLV*32-1:0]   PRDATA,
  input  logic [NUM_SLV-1:0]      PREADY,
  input  logic [NUM_SLV-1:0]      PSLVERR
);

  if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
    $error("apb_master_ctrl: NUM_SLV must be in 1..16");
  end

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("apb_master_ctrl: TIMEOUT_CYC must be at least 1");
  end

  apb_state_e           state;
  logic                 dec_hit;
  logic [NUM_SLV-1:0]   dec_sel;
  logic                 sel_ready;
  logic                 sel_err;
  logic [31:0]          sel_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0]     wait_cnt;
`endif

  apb_addr_decoder #(
    .NUM_SLV (NUM_SLV)
  ) u_decoder (
    .busAddr (busAddr[31:12]),
    .hit     (dec_hit),
    .sel     (dec_sel)
  );

  // Pick the response lines of the slave currently selected; unselected slaves never matter.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (PSEL[i]) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[32*i +: 32];
      end
    end
  end

  // Protocol sequencer: every APB and CPU-side output is a register updated here.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      PSEL     <= '0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      busRData <= '0;
      ready    <= 1'b0;
      err      <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (transfer) begin
            if (dec_hit) begin
              PADDR  <= busAddr;
              PWRITE <= busWe;
              PWDATA <= busWData;
              PSEL   <= dec_sel;
              state  <= SETUP;
            end else begin
              ready    <= 1'b1;
              err      <= 1'b1;
              busRData <= '0;
            end
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (sel_ready) begin
            if (!PWRITE) begin
              busRData <= sel_err ? 32'h0 : sel_rdata;
            end
            ready   <= 1'b1;
            err     <= sel_err;
            PSEL    <= '0;
            PENABLE <= 1'b0;
            state   <= IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt == CNT_LAST) begin
            if (!PWRITE) begin
              busRData <= '0;
            end
            ready    <= 1'b1;
            err      <= 1'b1;
            PSEL     <= '0;
            PENABLE  <= 1'b0;
            wait_cnt <= wait_cnt + 1'b1;
            state    <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: table-driven cycle vectors plus hand-written
// sequences for reset, the ACCESS wait limit (APB_TIMEOUT_EN) and reset mid-transfer.
`timescale 1ns/1ps
module tb_apb_master_ctrl;

  localparam int NUM_SLV = 4;
  localparam int TO_CYC  = 8;
  localparam int NVEC    = 27;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  transfer;
  logic                  busWe;
  logic [31:0]           busAddr;
  logic [31:0]           busWData;
  logic [31:0]           busRData;
  logic                  ready;
  logic                  err;
  logic [31:0]           PADDR;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [NUM_SLV-1:0]    PSEL;
  logic                  PENABLE;
  logic [NUM_SLV*32-1:0] PRDATA;
  logic [NUM_SLV-1:0]    PREADY;
  logic [NUM_SLV-1:0]    PSLVERR;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        tr;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  prdy;
    logic [3:0]  pse;
    logic [3:0]  psel;
    logic        pen;
    logic        pwrite;
    logic        rdy;
    logic        er;
    logic [31:0] rdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } vec_t;

  vec_t vecs [NVEC];

  apb_master_ctrl #(
    .NUM_SLV     (NUM_SLV),
    .TIMEOUT_CYC (TO_CYC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .transfer (transfer),
    .busWe    (busWe),
    .busAddr  (busAddr),
    .busWData (busWData),
    .busRData (busRData),
    .ready    (ready),
    .err      (err),
    .PADDR    (PADDR),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  // Free-running clock, 10 ns period.
  always #5 clk = ~clk;

  // Each slave returns a fixed, distinct word so a wrong select shows up in busRData.
  assign PRDATA = {32'hC3C3_3333, 32'hB2B2_2222, 32'h1234_5678, 32'hA0A0_0000};

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the DUT clock them, return at the following negedge.
  task automatic applyStimulus(input logic tr, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] prdy,
                               input logic [3:0] pse);
    transfer = tr;
    busWe    = we;
    busAddr  = a;
    busWData = wd;
    PREADY   = prdy;
    PSLVERR  = pse;
    @(negedge clk);
  endtask

  // Idle cycles until ready rises or the budget runs out; lat counts the cycle reached.
  task automatic waitReady(input int maxCyc, input logic [3:0] prdy, input int start,
                           output int lat);
    lat = start;
    while (!ready && lat < maxCyc) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, prdy, 4'b0000);
      lat++;
    end
  endtask

  task automatic checkVec(input int k);
    checkOutput($sformatf("v%0d PSEL", k),     {28'h0, PSEL},     {28'h0, vecs[k].psel});
    checkOutput($sformatf("v%0d PENABLE", k),  {31'h0, PENABLE},  {31'h0, vecs[k].pen});
    checkOutput($sformatf("v%0d PWRITE", k),   {31'h0, PWRITE},   {31'h0, vecs[k].pwrite});
    checkOutput($sformatf("v%0d ready", k),    {31'h0, ready},    {31'h0, vecs[k].rdy});
    checkOutput($sformatf("v%0d err", k),      {31'h0, err},      {31'h0, vecs[k].er});
    checkOutput($sformatf("v%0d busRData", k), busRData,          vecs[k].rdata);
    checkOutput($sformatf("v%0d PADDR", k),    PADDR,             vecs[k].paddr);
    checkOutput($sformatf("v%0d PWDATA", k),   PWDATA,            vecs[k].pwdata);
  endtask

  initial begin
    int lat;
    int readySeen;

    //           tr    we    addr          wdata         prdy     pse      psel     pen   pw    rdy   er    rdata         paddr         pwdata
    // write slave 2, immediate PREADY
    vecs[0]  = '{1'b1, 1'b1, 32'h1000_2004, 32'hCAFE_F00D, 4'b0100, 4'b0000, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h1000_2004, 32'hCAFE_F00D};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h1000_2004, 32'hCAFE_F00D};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h1000_2004, 32'hCAFE_F00D};
    // read slave 1, three wait cycles; transfer requests during the wait are ignored
    vecs[3]  = '{1'b1, 1'b0, 32'h1000_1000, 32'hDEAD_0001, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_1000, 32'hDEAD_0001};
    vecs[4]  = '{1'b1, 1'b1, 32'h1000_2000, 32'h1111_1111, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_1000, 32'hDEAD_0001};
    vecs[5]  = '{1'b1, 1'b1, 32'h1000_2000, 32'h1111_1111, 4'b1101, 4'b1101, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_1000, 32'hDEAD_0001};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b1101, 4'b1101, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_1000, 32'hDEAD_0001};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b1101, 4'b1101, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_1000, 32'hDEAD_0001};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b0010, 4'b1101, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h1000_1000, 32'hDEAD_0001};
    // decode misses, back to back
    vecs[9]  = '{1'b1, 1'b0, 32'h2000_0000, 32'h0,         4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         32'h1000_1000, 32'hDEAD_0001};
    vecs[10] = '{1'b1, 1'b0, 32'h1000_5000, 32'h0,         4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         32'h1000_1000, 32'hDEAD_0001};
    vecs[11] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_1000, 32'hDEAD_0001};
    // read slave 3, immediate PREADY
    vecs[12] = '{1'b1, 1'b0, 32'h1000_3008, 32'h0,         4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_3008, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_3008, 32'h0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC3C3_3333, 32'h1000_3008, 32'h0};
    // read slave 0 with PSLVERR, then a write issued on the ready cycle
    vecs[15] = '{1'b1, 1'b0, 32'h1000_0010, 32'h0,         4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC3C3_3333, 32'h1000_0010, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b0001, 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 32'hC3C3_3333, 32'h1000_0010, 32'h0};
    vecs[17] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,         32'h1000_0010, 32'h0};
    vecs[18] = '{1'b1, 1'b1, 32'h1000_1000, 32'h55AA_55AA, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h1000_1000, 32'h55AA_55AA};
    vecs[19] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h1000_1000, 32'h55AA_55AA};
    vecs[20] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         32'h1000_1000, 32'h55AA_55AA};
    // read slave 2, then a write that must leave busRData untouched
    vecs[21] = '{1'b1, 1'b0, 32'h1000_2000, 32'h0,         4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_2000, 32'h0};
    vecs[22] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h1000_2000, 32'h0};
    vecs[23] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB2B2_2222, 32'h1000_2000, 32'h0};
    vecs[24] = '{1'b1, 1'b1, 32'h1000_3000, 32'h0F0F_0F0F, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 32'hB2B2_2222, 32'h1000_3000, 32'h0F0F_0F0F};
    vecs[25] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 32'hB2B2_2222, 32'h1000_3000, 32'h0F0F_0F0F};
    vecs[26] = '{1'b0, 1'b0, 32'h0,         32'h0,         4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0, 32'hB2B2_2222, 32'h1000_3000, 32'h0F0F_0F0F};

    // Reset held while a valid request is presented: nothing may start.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h1000_2000, 32'hFFFF_FFFF, 4'b1111, 4'b1111);
    applyStimulus(1'b1, 1'b1, 32'h1000_2000, 32'hFFFF_FFFF, 4'b1111, 4'b1111);
    checkOutput("reset PSEL",     {28'h0, PSEL},    32'h0);
    checkOutput("reset PENABLE",  {31'h0, PENABLE}, 32'h0);
    checkOutput("reset PWRITE",   {31'h0, PWRITE},  32'h0);
    checkOutput("reset PADDR",    PADDR,            32'h0);
    checkOutput("reset PWDATA",   PWDATA,           32'h0);
    checkOutput("reset busRData", busRData,         32'h0);
    checkOutput("reset ready",    {31'h0, ready},   32'h0);
    checkOutput("reset err",      {31'h0, err},     32'h0);
    reset = 1'b1;

    // Cycle-by-cycle vector table.
    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(vecs[k].tr, vecs[k].we, vecs[k].addr, vecs[k].wdata,
                    vecs[k].prdy, vecs[k].pse);
      checkVec(k);
    end

    // Slave 3 never answers a read.
    applyStimulus(1'b1, 1'b0, 32'h1000_3000, 32'h0, 4'b0000, 4'b0000);
`ifdef APB_TIMEOUT_EN
    waitReady(40, 4'b0000, 1, lat);
    checkOutput("timeout latency",  lat,              32'd10);
    checkOutput("timeout err",      {31'h0, err},     32'h1);
    checkOutput("timeout busRData", busRData,         32'h0);
    checkOutput("timeout PSEL",     {28'h0, PSEL},    32'h0);
    checkOutput("timeout PENABLE",  {31'h0, PENABLE}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b1000, 4'b0000);
    checkOutput("late PREADY ready", {31'h0, ready},  32'h0);
    // Bring a fresh transfer into ACCESS for the reset check below.
    applyStimulus(1'b1, 1'b0, 32'h1000_1000, 32'h0, 4'b0000, 4'b0000);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0000);
    checkOutput("pre-reset PENABLE", {31'h0, PENABLE}, 32'h1);
`else
    readySeen = 0;
    for (int c = 1; c < 100; c++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0111, 4'b0000);
      if (ready) readySeen++;
    end
    checkOutput("no-timeout ready count", readySeen,         32'd0);
    checkOutput("no-timeout PSEL",        {28'h0, PSEL},     32'h8);
    checkOutput("no-timeout PENABLE",     {31'h0, PENABLE},  32'h1);
    checkOutput("no-timeout PADDR",       PADDR,             32'h1000_3000);
`endif

    // Reset during ACCESS, with the selected slave ready on that very edge.
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b1111, 4'b0000);
    checkOutput("midreset PSEL",     {28'h0, PSEL},    32'h0);
    checkOutput("midreset PENABLE",  {31'h0, PENABLE}, 32'h0);
    checkOutput("midreset ready",    {31'h0, ready},   32'h0);
    checkOutput("midreset PADDR",    PADDR,            32'h0);
    checkOutput("midreset busRData", busRData,         32'h0);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b1111, 4'b0000);
    checkOutput("post-reset ready",  {31'h0, ready},   32'h0);

    // A normal write after release completes in the minimum three cycles.
    applyStimulus(1'b1, 1'b1, 32'h1000_0000, 32'h0000_0077, 4'b0001, 4'b0000);
    checkOutput("post-reset SETUP PSEL", {28'h0, PSEL}, 32'h1);
    waitReady(20, 4'b0001, 1, lat);
    checkOutput("post-reset latency", lat,            32'd3);
    checkOutput("post-reset err",     {31'h0, err},   32'h0);
    checkOutput("post-reset PWDATA",  PWDATA,         32'h0000_0077);
    checkOutput("post-reset PWRITE",  {31'h0, PWRITE}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'b0000, 4'b0000);
    checkOutput("ready single pulse", {31'h0, ready}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
